// File: rtl/fetch_stage_if.sv
// fetch_stage_if: instruction-memory, hazard/branch-control and IF/ID bundle
// of the fetch stage. The master side is the fetch stage itself.
interface fetch_stage_if #(
  parameter int unsigned WIDTH = 32
);
  // instruction memory
  logic [WIDTH-1:0] imem_addr;
  logic [WIDTH-1:0] imem_data;
  // hazard unit / branch resolution
  logic             stall;
  logic             redirect;
  logic [WIDTH-1:0] redirect_pc;
  // IF/ID pipeline register
  logic [WIDTH-1:0] ifid_pc;
  logic [WIDTH-1:0] ifid_pc_plus4;
  logic [WIDTH-1:0] ifid_instr;
  logic             ifid_valid;
  logic             misalign_err;

  modport master (
    output imem_addr,
    input  imem_data,
    input  stall,
    input  redirect,
    input  redirect_pc,
    output ifid_pc,
    output ifid_pc_plus4,
    output ifid_instr,
    output ifid_valid,
    output misalign_err
  );

  modport slave (
    input  imem_addr,
    output imem_data,
    output stall,
    output redirect,
    output redirect_pc,
    input  ifid_pc,
    input  ifid_pc_plus4,
    input  ifid_instr,
    input  ifid_valid,
    input  misalign_err
  );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: owns the PC, drives the instruction-memory address and
// registers the returned word into IF/ID. Edge priority is
// rst > redirect > stall > advance.
// Optional feature: define FETCH_PERF_EN to add the saturating
// perf_fetched / perf_bubbles counters.
module fetch_stage #(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_PC  = '0,
  parameter logic [WIDTH-1:0] NOP_INSTR = WIDTH'(32'h0000_0013)
) (
  input logic           clk,
  input logic           rst,
  fetch_stage_if.master bus
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]   perf_fetched,
  output logic [31:0]   perf_bubbles
`endif
);

  localparam int unsigned PERF_W = 32;

  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_plus4;
  logic [WIDTH-1:0] redirect_target;
  logic             redirect_misaligned;

  // Sequential next-PC and redirect target decode; wraps modulo 2^WIDTH.
  assign pc_plus4            = pc + WIDTH'(4);
  assign redirect_target     = {bus.redirect_pc[WIDTH-1:2], 2'b00};
  assign redirect_misaligned = (bus.redirect_pc[1:0] != 2'b00);

  // Memory address is the live PC so the word returns in the same cycle.
  assign bus.imem_addr = pc;

  // PC register.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (bus.redirect) begin
      pc <= redirect_target;
    end else if (!bus.stall) begin
      pc <= pc_plus4;
    end
  end

  // IF/ID register: flush inserts a bubble, stall holds, advance captures.
  always_ff @(posedge clk) begin
    if (rst || bus.redirect) begin
      bus.ifid_pc       <= '0;
      bus.ifid_pc_plus4 <= '0;
      bus.ifid_instr    <= NOP_INSTR;
      bus.ifid_valid    <= 1'b0;
    end else if (!bus.stall) begin
      bus.ifid_pc       <= pc;
      bus.ifid_pc_plus4 <= pc_plus4;
      bus.ifid_instr    <= bus.imem_data;
      bus.ifid_valid    <= 1'b1;
    end
  end

  // One-cycle pulse after a redirect whose target was not word aligned.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.misalign_err <= 1'b0;
    end else begin
      bus.misalign_err <= bus.redirect && redirect_misaligned;
    end
  end

`ifdef FETCH_PERF_EN
  // Saturating counters: advances vs. bubble-producing (redirect/stall) edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched <= '0;
      perf_bubbles <= '0;
    end else if (bus.redirect || bus.stall) begin
      if (perf_bubbles != {PERF_W{1'b1}}) begin
        perf_bubbles <= perf_bubbles + PERF_W'(1);
      end
    end else begin
      if (perf_fetched != {PERF_W{1'b1}}) begin
        perf_fetched <= perf_fetched + PERF_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed vectors for fetch_stage. Each step drives the
// inputs for one edge and queues the hand-computed post-edge state; a
// monitor pops one entry per edge and compares.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] pc;
    logic [31:0] plus4;
    logic [31:0] instr;
    logic        valid;
    logic        mis;
    logic [7:0]  id;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  exp_t q[$];
  exp_t e;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_bubbles;
`endif

  fetch_stage_if #(.WIDTH(32)) bus ();

  fetch_stage #(
    .WIDTH    (32),
    .RESET_PC (32'h0000_0000),
    .NOP_INSTR(NOP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched(perf_fetched),
    .perf_bubbles(perf_bubbles)
`endif
  );

  always #5 clk = ~clk;

  // Memory: word i holds 0x100+i, except a NOP planted at 0x200.
  assign bus.imem_data = (bus.imem_addr == 32'h0000_0200) ? NOP
                                                          : 32'h100 + (bus.imem_addr >> 2);

  task automatic chk(input string name, input logic [7:0] id,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step %0d: got %h expected %h", name, id, act, exp);
    end
  endtask

  // Drive one edge's inputs and queue the expected post-edge state.
  task automatic step(input logic [7:0] id, input logic r, input logic s,
                      input logic rd, input logic [31:0] rpc,
                      input logic [31:0] addr, input logic [31:0] pc,
                      input logic [31:0] plus4, input logic [31:0] instr,
                      input logic valid, input logic mis);
    exp_t x;
    @(negedge clk);
    rst             = r;
    bus.stall       = s;
    bus.redirect    = rd;
    bus.redirect_pc = rpc;
    x.addr = addr; x.pc = pc; x.plus4 = plus4; x.instr = instr;
    x.valid = valid; x.mis = mis; x.id = id;
    q.push_back(x);
  endtask

  // Monitor: compare DUT state after every edge that has a queued expectation.
  always @(posedge clk) begin
    #1;
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("imem_addr",     e.id, bus.imem_addr,     e.addr);
      chk("ifid_pc",       e.id, bus.ifid_pc,       e.pc);
      chk("ifid_pc_plus4", e.id, bus.ifid_pc_plus4, e.plus4);
      chk("ifid_instr",    e.id, bus.ifid_instr,    e.instr);
      chk("ifid_valid",    e.id, 32'(bus.ifid_valid),   32'(e.valid));
      chk("misalign_err",  e.id, 32'(bus.misalign_err), 32'(e.mis));
    end
  end

  initial begin
    rst = 1'b1; bus.stall = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = '0;
    //    id  rst st rd rpc            addr           pc             plus4          instr          v  mis
    step(0,  1, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0,        NOP,          0, 0); // reset
    step(1,  0, 0, 0, 32'h0,        32'h4,        32'h0,        32'h4,        32'h100,      1, 0);
    step(2,  0, 0, 0, 32'h0,        32'h8,        32'h4,        32'h8,        32'h101,      1, 0);
    step(3,  0, 1, 0, 32'h0,        32'h8,        32'h4,        32'h8,        32'h101,      1, 0); // stall
    step(4,  0, 1, 0, 32'h0,        32'h8,        32'h4,        32'h8,        32'h101,      1, 0); // stall
    step(5,  0, 0, 0, 32'h0,        32'hC,        32'h8,        32'hC,        32'h102,      1, 0);
    step(6,  0, 0, 0, 32'h0,        32'h10,       32'hC,        32'h10,       32'h103,      1, 0);
    step(7,  0, 0, 1, 32'h40,       32'h40,       32'h0,        32'h0,        NOP,          0, 0); // redirect
    step(8,  0, 0, 0, 32'h0,        32'h44,       32'h40,       32'h44,       32'h110,      1, 0);
    step(9,  0, 1, 1, 32'h80,       32'h80,       32'h0,        32'h0,        NOP,          0, 0); // redirect+stall
    step(10, 0, 1, 0, 32'h0,        32'h80,       32'h0,        32'h0,        NOP,          0, 0); // stall on bubble
    step(11, 0, 0, 0, 32'h0,        32'h84,       32'h80,       32'h84,       32'h120,      1, 0);
    step(12, 0, 0, 1, 32'h42,       32'h40,       32'h0,        32'h0,        NOP,          0, 1); // misaligned
    step(13, 0, 0, 0, 32'h0,        32'h44,       32'h40,       32'h44,       32'h110,      1, 0);
    step(14, 0, 0, 1, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'h0,        32'h0,        NOP,          0, 0);
    step(15, 0, 0, 0, 32'h0,        32'h0,        32'hFFFFFFFC, 32'h0,        32'h400000FF, 1, 0); // wrap
    step(16, 0, 0, 0, 32'h0,        32'h4,        32'h0,        32'h4,        32'h100,      1, 0);
    step(17, 0, 0, 1, 32'h200,      32'h200,      32'h0,        32'h0,        NOP,          0, 0);
    step(18, 0, 0, 0, 32'h0,        32'h204,      32'h200,      32'h204,      NOP,          1, 0); // fetched NOP is valid
    step(19, 1, 1, 1, 32'h40,       32'h0,        32'h0,        32'h0,        NOP,          0, 0); // reset wins
    step(20, 0, 0, 0, 32'h0,        32'h4,        32'h0,        32'h4,        32'h100,      1, 0);
    step(21, 0, 0, 0, 32'h0,        32'h8,        32'h4,        32'h8,        32'h101,      1, 0);
    step(22, 0, 1, 0, 32'h0,        32'h8,        32'h4,        32'h8,        32'h101,      1, 0);
    step(23, 0, 0, 0, 32'h0,        32'hC,        32'h8,        32'hC,        32'h102,      1, 0);
    step(24, 0, 0, 1, 32'h40,       32'h40,       32'h0,        32'h0,        NOP,          0, 0);
    step(25, 0, 1, 0, 32'h0,        32'h40,       32'h0,        32'h0,        NOP,          0, 0);
    @(negedge clk);
    bus.stall = 1'b1;
    // allow the monitor to drain, bounded
    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
    chk("queue_drained", 8'd99, 32'(q.size()), 32'd0);
`ifdef FETCH_PERF_EN
    // since reset at step 19: 3 advances (20,21,23); bubbles at 22,24,25 plus
    // the stall held above while draining
    chk("perf_fetched", 8'd99, perf_fetched, 32'd3);
    if (perf_bubbles < 32'd3) chk("perf_bubbles_min", 8'd99, perf_bubbles, 32'd3);
    else checks++;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
